// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with debounce, one key_in strobe per press, and a debounced clear button.
// Optional build macro KEYPAD_LONGCLR_EN: holding a key for LONG_CYCLES clocks after key_in emits one clear.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV    = 16,
  parameter int DEBOUNCE    = 4,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  input  logic       clr_btn,
  output logic [3:0] col_out,
  output logic       key_in,
  output logic [3:0] key_val,
  output logic       clear,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int KW = $clog2(DEBOUNCE * SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
  localparam logic [KW-1:0] CLR_LAST = KW'(DEBOUNCE * SCAN_DIV - 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEB, ST_PRESSED, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic [3:0]    code_q, code_d, key_val_q, key_val_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic          clr_s1_q, clr_s2_q;
  logic          clr_db_q, clr_db_d;
  logic [KW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clear_q, clear_d;
  logic          sample, any_low, clr_rise, long_fire;
  logic [1:0]    low_idx;

  assign sample  = (div_q == DIV_LAST);
  assign any_low = ~&row_s2_q;

  // Lowest pressed row wins when several keys share a column.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!row_s2_q[i]) low_idx = 2'(i);
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    div_d     = sample ? '0 : div_q + 1'b1;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    code_d    = code_q;
    key_val_d = key_val_q;
    case (state_q)
      ST_SCAN: if (sample) begin
        if (any_low) begin
          code_d = {low_idx, col_idx_q};
          cnt_d  = CW'(1);
          if (DEBOUNCE == 1) begin
            state_d   = ST_PRESSED;
            key_val_d = {low_idx, col_idx_q};
          end else begin
            state_d = ST_DEB;
          end
        end else begin
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      ST_DEB: if (sample) begin
        if (any_low && low_idx == code_q[3:2]) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) begin
            state_d   = ST_PRESSED;
            key_val_d = code_q;
          end
        end else begin
          state_d   = ST_SCAN;
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      // A clear landing on this cycle wins; the strobe slips one clock.
      ST_PRESSED: if (!clear_q) begin
        state_d = ST_HOLD;
        rcnt_d  = '0;
      end
      ST_HOLD: if (sample) begin
        if (any_low) begin
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_d == CNT_MAX) begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_comb begin
    clr_db_d  = clr_db_q;
    clr_cnt_d = '0;
    clr_rise  = 1'b0;
    if (clr_s2_q != clr_db_q) begin
      if (clr_cnt_q == CLR_LAST) begin
        clr_db_d = clr_s2_q;
        clr_rise = clr_s2_q;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

`ifdef KEYPAD_LONGCLR_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // hold_cnt equals clocks elapsed since key_in; saturates so it fires once per press.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    long_fire  = 1'b0;
    if (state_q == ST_PRESSED) begin
      hold_cnt_d = HW'(1);
    end else if (state_q == ST_HOLD && hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      long_fire  = (hold_cnt_q == HOLD_FIRE);
    end
  end

  always_ff @(posedge clock)
    if (!reset) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
`else
  assign long_fire = 1'b0;
`endif

  assign clear_d = clr_rise | long_fire;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_SCAN;
      col_idx_q <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      code_q    <= '0;
      key_val_q <= '0;
      row_s1_q  <= '0;
      row_s2_q  <= '0;
      clr_s1_q  <= 1'b0;
      clr_s2_q  <= 1'b0;
      clr_db_q  <= 1'b0;
      clr_cnt_q <= '0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      code_q    <= code_d;
      key_val_q <= key_val_d;
      row_s1_q  <= row_in;
      row_s2_q  <= row_s1_q;
      clr_s1_q  <= clr_btn;
      clr_s2_q  <= clr_s1_q;
      clr_db_q  <= clr_db_d;
      clr_cnt_q <= clr_cnt_d;
      clear_q   <= clear_d;
    end
  end

  assign col_out  = ~(4'b0001 << col_idx_q);
  assign key_in   = (state_q == ST_PRESSED) && !clear_q;
  assign key_held = key_in || (state_q == ST_HOLD);
  assign key_val  = key_val_q;
  assign clear    = clear_q;

endmodule
